// File: rtl/blink_pattern_rx.sv
// blink_pattern_rx
//   Receive end of the pin-level blink link. A blink generator sends one bit
//   every 2^SLOT_LOG2 clocks, LSB first, FRAME_BITS bits per frame. A frame
//   starts with a rising edge after at least SYNC_ZEROS low slots. This block
//   recovers the slot timing, captures each frame and compares it with
//   EXPECTED.
//
//   Build option: GLITCH_FILTER_EN
//     defined   - the synchronized pin is only accepted after 3 consecutive
//                 equal samples (+2 cycles latency, pulses < 3 cycles dropped)
//     undefined - every transition of the synchronized pin is an edge
//
// Ports
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   pin          in   asynchronous serial blink input
//   pattern      out  last complete frame, bit0 = first slot received
//   frame_valid  out  1-cycle pulse: pattern/match updated
//   match        out  last frame == EXPECTED
//   locked       out  set on a matching frame, cleared on mismatch or frame_err
//   frame_err    out  1-cycle pulse: new frame start before the frame completed
//   frame_count  out  number of frame_valid pulses, wraps 255 -> 0
//
// state | meaning
// ------+-------------------------------------------------------------
// HUNT  | idle, waiting for a rise after a long enough low run
// RECV  | receiving a frame, slot timer running, sampling mid-slot

module blink_pattern_rx #(
  parameter int unsigned SLOT_LOG2  = 21,
  parameter int unsigned FRAME_BITS = 32,
  parameter int unsigned SYNC_ZEROS = 4,
  parameter logic [31:0] EXPECTED   = 32'h071C71C7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pin,
  output logic [FRAME_BITS-1:0] pattern,
  output logic                  frame_valid,
  output logic                  match,
  output logic                  locked,
  output logic                  frame_err,
  output logic [7:0]            frame_count
);

  localparam int unsigned LW = SLOT_LOG2 + 4;
  localparam int unsigned BW = $clog2(FRAME_BITS);

  // Minimum low run before a rise counts as a frame start: SYNC_ZEROS slots
  // minus half a slot of slack for clock mismatch between the two ends.
  localparam logic [LW-1:0] START_MIN =
    LW'((SYNC_ZEROS << SLOT_LOG2) - (1 << (SLOT_LOG2 - 1)));
  localparam logic [SLOT_LOG2-1:0] T_HALF   = SLOT_LOG2'(1 << (SLOT_LOG2 - 1));
  localparam logic [SLOT_LOG2-1:0] T_SAMPLE = SLOT_LOG2'((1 << (SLOT_LOG2 - 1)) - 1);
  localparam logic [SLOT_LOG2-1:0] T_MAX    = '1;
  localparam logic [BW-1:0]        B_LAST   = BW'(FRAME_BITS - 1);
  localparam logic [LW-1:0]        LOW_SAT  = '1;

  typedef enum logic {
    HUNT = 1'b0,
    RECV = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic                  sync1_q, sync1_d;
  logic                  sync2_q, sync2_d;
  logic                  s;
  logic                  s_q, s_d;
  logic [LW-1:0]         lowrun_q, lowrun_d;
  logic [SLOT_LOG2-1:0]  t_q, t_d;
  logic [BW-1:0]         b_q, b_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [FRAME_BITS-1:0] pattern_q, pattern_d;
  logic                  frame_valid_q, frame_valid_d;
  logic                  match_q, match_d;
  logic                  locked_q, locked_d;
  logic                  frame_err_q, frame_err_d;
  logic [7:0]            frame_count_q, frame_count_d;

  logic                  rise;
  logic                  fall;
  logic                  edge_det;
  logic                  start;
  logic                  frame_eq;
  logic [FRAME_BITS-1:0] frame_w;

  assign sync1_d = pin;
  assign sync2_d = sync1_q;

`ifdef GLITCH_FILTER_EN
  logic [1:0] hist_q, hist_d;
  logic       filt_q, filt_d;

  // The filtered level follows the synchronizer only once the current and
  // the two previous samples agree; the decision is used combinationally so
  // the added latency is exactly two cycles.
  always_comb begin
    hist_d = {hist_q[0], sync2_q};
    filt_d = filt_q;
    if ((sync2_q == hist_q[0]) && (sync2_q == hist_q[1])) begin
      filt_d = sync2_q;
    end
  end

  assign s = filt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      filt_q <= 1'b0;
    end else begin
      hist_q <= hist_d;
      filt_q <= filt_d;
    end
  end
`else
  assign s = sync2_q;
`endif

  assign s_d      = s;
  assign rise     = s & ~s_q;
  assign fall     = ~s & s_q;
  assign edge_det = rise | fall;
  assign start    = rise && (lowrun_q >= START_MIN);

  // Low-run counter runs in every state; it is what qualifies a frame start.
  always_comb begin
    lowrun_d = lowrun_q;
    if (s) begin
      lowrun_d = '0;
    end else if (lowrun_q != LOW_SAT) begin
      lowrun_d = lowrun_q + 1'b1;
    end
  end

  // Current frame with the slot being sampled merged in.
  always_comb begin
    frame_w      = shift_q;
    frame_w[b_q] = s;
  end

  assign frame_eq = (frame_w == EXPECTED[FRAME_BITS-1:0]);

  always_comb begin
    state_d       = state_q;
    t_d           = t_q;
    b_d           = b_q;
    shift_d       = shift_q;
    pattern_d     = pattern_q;
    frame_valid_d = 1'b0;
    match_d       = match_q;
    locked_d      = locked_q;
    frame_err_d   = 1'b0;
    frame_count_d = frame_count_q;

    case (state_q)
      HUNT: begin
        if (start) begin
          state_d = RECV;
          t_d     = '0;
          b_d     = '0;
          shift_d = '0;
        end
      end

      RECV: begin
        if (start) begin
          // Frame cut short by a new start: report it, keep the last good
          // pattern, and begin receiving the new frame straight away.
          frame_err_d = 1'b1;
          locked_d    = 1'b0;
          t_d         = '0;
          b_d         = '0;
          shift_d     = '0;
        end else begin
          t_d = t_q + 1'b1;
          if (t_q == T_MAX) begin
            b_d = b_q + 1'b1;
          end

          if (t_q == T_SAMPLE) begin
            shift_d = frame_w;
            if (b_q == B_LAST) begin
              pattern_d     = frame_w;
              match_d       = frame_eq;
              locked_d      = frame_eq;
              frame_valid_d = 1'b1;
              frame_count_d = frame_count_q + 8'd1;
              state_d       = HUNT;
            end
          end

          // Realign on every edge. An edge in the second half of the slot
          // means the sender is ahead of us: it already started the next bit.
          if (edge_det) begin
            t_d = '0;
            if (t_q >= T_HALF) begin
              b_d = b_q + 1'b1;
            end else begin
              b_d = b_q;
            end
          end
        end
      end

      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= HUNT;
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      s_q           <= 1'b0;
      lowrun_q      <= '0;
      t_q           <= '0;
      b_q           <= '0;
      shift_q       <= '0;
      pattern_q     <= '0;
      frame_valid_q <= 1'b0;
      match_q       <= 1'b0;
      locked_q      <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      s_q           <= s_d;
      lowrun_q      <= lowrun_d;
      t_q           <= t_d;
      b_q           <= b_d;
      shift_q       <= shift_d;
      pattern_q     <= pattern_d;
      frame_valid_q <= frame_valid_d;
      match_q       <= match_d;
      locked_q      <= locked_d;
      frame_err_q   <= frame_err_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign pattern     = pattern_q;
  assign frame_valid = frame_valid_q;
  assign match       = match_q;
  assign locked      = locked_q;
  assign frame_err   = frame_err_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_blink_pattern_rx.sv
// tb_blink_pattern_rx
//   Drives blink frames at 16 clk/slot (and 15/17 for drift), including
//   random frames, a truncated frame and a reset in mid-frame. A queue of
//   expected events is filled by the sender; a monitor pops it on every
//   frame_valid / frame_err pulse and checks the outputs against a simple
//   model of last pattern, match, lock state and frame count.

module tb_blink_pattern_rx;

  localparam int          SL  = 4;
  localparam int          L   = 16;
  localparam logic [31:0] EXP = 32'h071C71C7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pin = 1'b0;
  logic [31:0] pattern;
  logic        frame_valid;
  logic        match;
  logic        locked;
  logic        frame_err;
  logic [7:0]  frame_count;

  blink_pattern_rx #(
    .SLOT_LOG2 (SL),
    .FRAME_BITS(32),
    .SYNC_ZEROS(4),
    .EXPECTED  (EXP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pin        (pin),
    .pattern    (pattern),
    .frame_valid(frame_valid),
    .match      (match),
    .locked     (locked),
    .frame_err  (frame_err),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_err;
    logic [31:0] v;
    int          cs;
    int          len;
  } item_t;

  item_t q[$];
  item_t it;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          rst_pulses = 0;
  int          lo_w, hi_w;
  logic [31:0] pattern_m = '0;
  bit          match_m = 1'b0;
  bit          locked_m = 1'b0;
  int          count_m = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Random frame made of alternating runs of 1..3 slots, starting with 1, so
  // it both starts with a rise and never contains a start-qualifying low run.
  function automatic logic [31:0] gen_frame();
    logic [31:0] v;
    int          i;
    bit          val;
    v   = '0;
    i   = 0;
    val = 1'b1;
    while (i < 32) begin
      int r;
      r = $urandom_range(1, 3);
      for (int k = 0; k < r && i < 32; k++) begin
        v[i] = val;
        i++;
      end
      val = ~val;
    end
    return v;
  endfunction

  // Sends one frame plus a 5-slot low gap. glitch_slot >= 0 inserts a 1-clk
  // high pulse in the middle of that (low) slot.
  task automatic send_frame(input logic [31:0] v, input int len, input int glitch_slot,
                            input bit push);
    item_t e;
    e.is_err = 1'b0;
    e.v      = v;
    e.cs     = cyc;
    e.len    = len;
    if (push) q.push_back(e);
    for (int i = 0; i < 32; i++) begin
      pin = v[i];
      if (i == glitch_slot) begin
        repeat (len / 2) tick();
        pin = 1'b1;
        tick();
        pin = v[i];
        repeat (len - len / 2 - 1) tick();
      end else begin
        repeat (len) tick();
      end
    end
    pin = 1'b0;
    repeat (5 * len) tick();
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      if (frame_valid || frame_err) rst_pulses++;
    end else begin
      if (frame_valid) begin
        chk("fv_expected", 32'(q.size() > 0 && !q[0].is_err), 32'd1);
        if (q.size() > 0 && !q[0].is_err) begin
          it        = q.pop_front();
          pattern_m = it.v;
          match_m   = (it.v == EXP);
          locked_m  = match_m;
          count_m   = (count_m + 1) % 256;
          lo_w      = it.cs + 31 * it.len + it.len / 4;
          hi_w      = it.cs + 31 * it.len + (3 * it.len) / 4 + 8;
          chk("fv_pattern", pattern, pattern_m);
          chk("fv_match", 32'(match), 32'(match_m));
          chk("fv_locked", 32'(locked), 32'(locked_m));
          chk("fv_count", 32'(frame_count), 32'(count_m));
          chk("fv_timing", 32'(cyc >= lo_w && cyc <= hi_w), 32'd1);
        end
      end
      if (frame_err) begin
        chk("err_expected", 32'(q.size() > 0 && q[0].is_err), 32'd1);
        if (q.size() > 0 && q[0].is_err) begin
          it       = q.pop_front();
          locked_m = 1'b0;
          chk("err_locked", 32'(locked), 32'(locked_m));
          chk("err_pattern_kept", pattern, pattern_m);
          chk("err_match_kept", 32'(match), 32'(match_m));
          chk("err_no_fv", 32'(frame_valid), 32'd0);
        end
      end
    end
  end

  initial begin
    item_t       e;
    logic [31:0] v;
    int          len;

    // Reset with the pin toggling.
    rst_n = 1'b0;
    repeat (20) begin
      tick();
      pin = 1'($urandom_range(0, 1));
    end
    chk("rst_pattern", pattern, 32'd0);
    chk("rst_match", 32'(match), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_count", 32'(frame_count), 32'd0);
    chk("rst_fv", 32'(frame_valid), 32'd0);
    chk("rst_err", 32'(frame_err), 32'd0);
    chk("rst_pulses", 32'(rst_pulses), 32'd0);
    pin = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (100) tick();

    // Two good frames, then one with bit4 flipped.
    send_frame(EXP, L, -1, 1'b1);
    send_frame(EXP, L, -1, 1'b1);
    chk("two_frames_count", 32'(frame_count), 32'd2);
    chk("two_frames_locked", 32'(locked), 32'd1);
    send_frame(EXP ^ 32'h10, L, -1, 1'b1);
    chk("bad_frame_locked", 32'(locked), 32'd0);
    chk("bad_frame_match", 32'(match), 32'd0);

    // Truncated frame: start, 3 high slots, 6 low slots, then a good frame.
    e.is_err = 1'b1;
    e.v      = '0;
    e.cs     = cyc;
    e.len    = L;
    q.push_back(e);
    pin = 1'b1;
    repeat (3 * L) tick();
    pin = 1'b0;
    repeat (6 * L) tick();
    send_frame(EXP, L, -1, 1'b1);
    chk("after_err_match", 32'(match), 32'd1);

    // Slot length off by one in both directions.
    send_frame(EXP, 15, -1, 1'b1);
    send_frame(EXP, 17, -1, 1'b1);
    chk("drift_locked", 32'(locked), 32'd1);

    // Random frames at random slot lengths.
    repeat (12) begin
      len = $urandom_range(15, 17);
      v   = ($urandom_range(0, 2) == 0) ? EXP : gen_frame();
      send_frame(v, len, -1, 1'b1);
    end

`ifdef GLITCH_FILTER_EN
    send_frame(EXP, L, 28, 1'b1);
    chk("glitch_match", 32'(match), 32'd1);
`endif

    // Reset during slot 10 of a frame; the rest of that frame is ignored.
    for (int i = 0; i < 10; i++) begin
      pin = EXP[i];
      repeat (L) tick();
    end
    pin   = EXP[10];
    rst_n = 1'b0;
    #1;
    chk("midrst_pattern", pattern, 32'd0);
    chk("midrst_locked", 32'(locked), 32'd0);
    chk("midrst_count", 32'(frame_count), 32'd0);
    pattern_m  = '0;
    match_m    = 1'b0;
    locked_m   = 1'b0;
    count_m    = 0;
    rst_pulses = 0;
    repeat (L) tick();
    rst_n = 1'b1;
    for (int i = 11; i < 32; i++) begin
      pin = EXP[i];
      repeat (L) tick();
    end
    pin = 1'b0;
    repeat (5 * L) tick();
    chk("midrst_no_pulses", 32'(rst_pulses), 32'd0);
    chk("midrst_no_frame", 32'(frame_count), 32'd0);
    send_frame(EXP, L, -1, 1'b1);
    chk("midrst_fresh_count", 32'(frame_count), 32'd1);
    chk("midrst_fresh_locked", 32'(locked), 32'd1);

    repeat (20) tick();
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
